// File: rtl/seq_gen.sv
// rtl/seq_gen.sv - serial pattern transmitter with repeat, idle gaps and start/busy/done handshake
module seq_gen #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   REP_W    = 3,
    parameter int   GAP      = 2,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] repeat_n,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Gap counter runs GAP-1 down to 0; keep at least one bit when GAP is 0 or 1.
    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);

    logic [1:0]       state, nxt_state;
    logic [WIDTH-1:0] pat_q, nxt_pat;
    logic [LEN_W-1:0] len_q, nxt_len;
    logic [REP_W-1:0] rep_q, nxt_rep;
    logic [LEN_W-1:0] idx, nxt_idx;
    logic [GAP_W-1:0] gap_q, nxt_gap;
    logic             nxt_dout, nxt_valid, nxt_busy, nxt_done, nxt_err;
    logic [WIDTH-1:0] shifted;

    // Next-state and registered-output decode; outputs follow the state being entered.
    always_comb begin
        nxt_state = state;
        nxt_pat   = pat_q;
        nxt_len   = len_q;
        nxt_rep   = rep_q;
        nxt_idx   = idx;
        nxt_gap   = gap_q;
        nxt_err   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    if (len != '0 && len <= LEN_MAX) begin
                        nxt_state = S_SHIFT;
                        nxt_pat   = pattern;
                        nxt_len   = len;
                        nxt_rep   = repeat_n;
                        nxt_idx   = len - LEN_W'(1);
                    end else begin
                        nxt_err = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (idx != '0) begin
                    nxt_idx = idx - LEN_W'(1);
                end else if (rep_q != '0) begin
                    nxt_rep = rep_q - REP_W'(1);
                    if (GAP > 0) begin
                        nxt_state = S_GAP;
                        nxt_gap   = GAP_LAST;
                    end else begin
                        nxt_idx = len_q - LEN_W'(1);
                    end
                end else begin
                    nxt_state = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    nxt_state = S_SHIFT;
                    nxt_idx   = len_q - LEN_W'(1);
                end else begin
                    nxt_gap = gap_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        // Cancel beats every other transition once a transfer is under way.
        if (abort && state != S_IDLE) begin
            nxt_state = S_IDLE;
        end

        shifted   = nxt_pat >> nxt_idx;
        nxt_dout  = IDLE_LVL;
        nxt_valid = 1'b0;
        nxt_busy  = 1'b0;
        nxt_done  = 1'b0;
        case (nxt_state)
            S_SHIFT: begin
                nxt_dout  = shifted[0];
                nxt_valid = 1'b1;
                nxt_busy  = 1'b1;
            end
            S_GAP: begin
                nxt_busy = 1'b1;
            end
            S_DONE: begin
                nxt_done = 1'b1;
            end
            default: begin
                nxt_dout = IDLE_LVL;
            end
        endcase
    end

    // State, captured transfer parameters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pat_q      <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            idx        <= '0;
            gap_q      <= '0;
            dout       <= IDLE_LVL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt_state;
            pat_q      <= nxt_pat;
            len_q      <= nxt_len;
            rep_q      <= nxt_rep;
            idx        <= nxt_idx;
            gap_q      <= nxt_gap;
            dout       <= nxt_dout;
            dout_valid <= nxt_valid;
            busy       <= nxt_busy;
            done       <= nxt_done;
            err        <= nxt_err;
        end
    end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter: the driving end of the single-bit serial line that the sequence detector consumes.
- Loads a pattern word of programmable bit length and shifts it out MSB-first on one output bit, optionally repeated with idle gaps.
- Reports progress through a start/busy/done handshake.
- Sits upstream of the detector in lab datapaths and benches; its dout connects to the detector's x input.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of len input; must satisfy 2**LEN_W > WIDTH.
- REP_W, 3, width of repeat count input.
- GAP, 2, idle cycles inserted between repetitions (0 allowed).
- IDLE_LVL, 1, dout level whenever no pattern bit is being driven.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; active field is pattern[len-1:0].
- len  input  LEN_W  number of bits per transmission, valid range 1..WIDTH.
- repeat_n  input  REP_W  extra repetitions; total transmissions = repeat_n+1.
- abort  input  1  synchronous cancel.
- dout  output  1  serial data (registered).
- dout_valid  output  1  high while dout carries a pattern bit (registered).
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release at next edge):
  - state=IDLE, dout=IDLE_LVL, dout_valid=0, busy=0, done=0, err=0.
  - All internal registers cleared.
- States: IDLE, SHIFT, GAP, DONE. Encoding is free, but there must be no unreachable lockup; any illegal encoding returns to IDLE.
- IDLE:
  - start=1 with 1<=len<=WIDTH at edge E0: capture pattern, len and repeat_n into internal registers; bit index=len-1; go to SHIFT.
  - The first bit, pattern[len-1], appears on dout with dout_valid=1 in the cycle after E0.
  - start=1 with len=0 or len>WIDTH: stay in IDLE, err=1 for exactly one cycle.
  - start=0: hold IDLE outputs.
- SHIFT:
  - One bit per cycle, MSB of the active field first: pattern[len-1] down to pattern[0].
  - After the bit at index 0 has been driven:
    - If repetitions remain and GAP>0: go to GAP.
    - If repetitions remain and GAP=0: reload index=len-1 and continue SHIFT with no idle cycle.
    - Otherwise: go to DONE.
  - Each completed transmission decrements the remaining-repetition count.
- GAP:
  - Exactly GAP cycles with dout=IDLE_LVL, dout_valid=0, busy=1.
  - Then reload index=len-1 and go to SHIFT.
- DONE:
  - One cycle: done=1, busy=0, dout=IDLE_LVL, dout_valid=0.
  - Unconditionally return to IDLE; start is not sampled in DONE.
- Input changes after capture:
  - Changes to pattern, len and repeat_n have no effect until the next accepted start.
  - start asserted while busy is ignored, with no err.
- abort=1 in SHIFT, GAP or DONE: next state is IDLE with IDLE outputs, and no done pulse. abort has priority over all transitions. abort in IDLE has no effect; if abort and start are both high in IDLE, abort wins and start is ignored.
- Latency:
  - start edge to first valid bit: 1 cycle.
  - Total busy cycles = (repeat_n+1)*len + repeat_n*GAP.
  - done asserts the cycle after the last bit.
- Counters:
  - Bit index is LEN_W wide; repetition counter is REP_W wide.
  - No wrap-around: terminate on index==0 and count==0 compares, never on underflow.
- Reset asserted mid-operation: immediate return to reset values; no done.

Test Plan:
- Basic: pattern=8'b00000110, len=3, repeat_n=0, pulse start -> dout_valid high for 3 cycles with dout=1,1,0, then done pulse for 1 cycle, busy low, dout=1.
- Repeat/gap (GAP=2): pattern=8'b00000101, len=3, repeat_n=2 -> dout=101,1,1,101,1,1,101 with dout_valid=0 on gap cycles; busy for 13 cycles; done once.
- Full width, MSB first: pattern=8'hA5, len=8 -> dout=1,0,1,0,0,1,0,1; an input change to 8'hFF mid-shift has no effect.
- Rejects: len=0 -> err pulses 1 cycle, busy stays 0; len=9 -> err; start while busy -> no err, sequence uninterrupted.
- Abort/reset: abort on the 2nd bit of len=5 -> IDLE next cycle, dout=IDLE_LVL, no done. reset=0 mid-GAP -> all outputs at reset values immediately.
- Loopback: drive the detector's x from dout with a pattern containing "110" -> detector z asserts on the expected cycle.
